wave_gen: RTL and testbench
===========================

WAVE_GEN -- requirements
Module: wave_gen

Interface
REQ-001 SHALL have ports: clk  input  1  sample clock, same domain as the DA address counter.
REQ-002 SHALL have: rst_n  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have: rd_addr  input  8  waveform phase/address from the downstream DA stage.
REQ-004 SHALL have: rd_data  output  8  offset-binary sample to the DA stage (128 = midscale).
REQ-005 SHALL have: cfg_valid  input  1  configuration offer.
REQ-006 SHALL have: cfg_wave  input  2  waveform select: 0 sine, 1 square, 2 triangle, 3 sawtooth.
REQ-007 SHALL have: cfg_amp  input  8  gain; unity = 128; values above 128 are treated as 128.
REQ-008 SHALL have: cfg_ready  output  1  high when a configuration can be accepted.
REQ-009 SHALL have: cfg_applied  output  1  one-cycle pulse when a pending configuration takes effect.

Function
REQ-010 Raw sample s(addr) SHALL be:
- square: 255 if addr[7]=0, else 0.
- triangle: {addr[6:0],0} if addr[7]=0, else bitwise-NOT of {addr[6:0],0}.
- sawtooth: addr.
REQ-011 Sine SHALL use a 64-entry quarter table m(i) = min(127, floor(128*sin(pi*(2i+1)/256))).
- Index j = addr[5:0] if addr[6]=0, else ~addr[5:0].
- s = 128+m(j) if addr[7]=0, else 127-m(j).
REQ-012 Output SHALL be rd_data = 128 + ((s-128)*g >>> 7), where g = min(cfg_amp, 128).
- Signed 9-bit x 8-bit product; arithmetic right shift (floor).
- Result is always within 0..255; no saturation logic is required.
REQ-013 Latency SHALL be exactly 2 clk cycles from rd_addr to rd_data.
- Stage 1 registers the raw sample with the active wave/amp captured alongside it.
- Stage 2 registers the scaled result.
REQ-014 A configuration SHALL be accepted in a cycle where cfg_valid=1 and cfg_ready=1; accepted values are held in a pending register.
REQ-015 cfg_ready SHALL be 0 while a configuration is pending and 1 otherwise.
- cfg_valid while cfg_ready=0 is ignored.
REQ-016 A pending configuration SHALL become active on the first stage-1 sample with rd_addr=0 strictly after the acceptance cycle.
- An acceptance in the same cycle as rd_addr=0 waits for the next wrap.
REQ-017 On activation, that rd_addr=0 sample and all later samples SHALL use the new configuration; no period SHALL mix configurations.
REQ-018 cfg_applied SHALL pulse in the activation cycle; cfg_ready SHALL return to 1 in the following cycle.
REQ-019 rd_addr is free-running with 8-bit wrap; a non-monotonic rd_addr SHALL still produce s(addr) per REQ-010/011 with no error state.

Reset
REQ-020 On rst_n low, state SHALL clear asynchronously:
- rd_data = 128, both pipeline stages = 128.
- active wave = sine, active gain = 128.
- pending cleared, cfg_ready = 1, cfg_applied = 0.
REQ-021 A reset asserted mid-operation SHALL discard any pending configuration.
REQ-022 The first valid sample SHALL appear 2 cycles after rst_n deassertion.

Structure
REQ-023 The shared package wave_pkg SHALL hold the waveform-select encodings, MIDSCALE=128 and AMP_UNITY=128.
REQ-024 The quarter-sine table SHALL be the sub-module sine_quarter_lut (6-bit index in, 7-bit magnitude out, combinational).
- Registering happens in stage 1 of wave_gen.

Verification
REQ-025 Reset defaults:
- Stimulus: reset, then rd_addr = 0, 64, 128, 192 in successive cycles.
- Response: rd_data = 129, 255, 126, 0 starting 2 cycles later.
REQ-026 Config alignment:
- Stimulus: at rd_addr=10 offer wave=3, amp=128.
- Response: cfg_ready drops; the rest of the period stays sine; the addr=0 sample outputs 0 and the addr=200 sample outputs 200.
- Response: cfg_applied pulses once.
REQ-027 Gain:
- Stimulus: square wave at amp=64.
- Response: rd_data alternates between 191 and 64.
- Stimulus: amp=0. Response: constant 128.
- Stimulus: amp=200. Response: identical to amp=128.
REQ-028 Handshake:
- Stimulus: second cfg_valid while pending.
- Response: ignored; acceptance occurs only after cfg_ready returns to 1.
REQ-029 Boundary:
- Stimulus: acceptance coincident with rd_addr=0.
- Response: activation at the next wrap, 256 cycles later.
REQ-030 Mid-operation reset:
- Stimulus: reset asserted with a configuration pending.
- Response: rd_data = 128 immediately; sine/unity gain after release; no cfg_applied pulse.

Source files
------------

// File: rtl/wave_pkg.sv
// wave_pkg: waveform-select encodings, MIDSCALE/AMP_UNITY constants and gain clamp shared by wave_gen
package wave_pkg;
  typedef enum logic [1:0] {WAVE_SINE, WAVE_SQUARE, WAVE_TRI, WAVE_SAW} wave_t;
  localparam logic [7:0] MIDSCALE = 8'd128;
  localparam logic [7:0] AMP_UNITY = 8'd128;
  function automatic logic [7:0] clamp_gain(input logic [7:0] amp);
    return amp > AMP_UNITY ? AMP_UNITY : amp;
  endfunction
endpackage

// File: rtl/sine_quarter_lut.sv
// sine_quarter_lut: combinational quarter-sine magnitude table; idx[5:0] in, mag[6:0] = min(127, floor(128*sin(pi*(2*idx+1)/256))) out
module sine_quarter_lut (
  input  logic [5:0] idx,
  output logic [6:0] mag
);
  localparam logic [6:0] TBL [64] = '{
    7'd1,   7'd4,   7'd7,   7'd10,  7'd14,  7'd17,  7'd20,  7'd23,
    7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
    7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
    7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd87,  7'd89,
    7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
    7'd107, 7'd108, 7'd110, 7'd112, 7'd113, 7'd115, 7'd116, 7'd117,
    7'd118, 7'd119, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124, 7'd125,
    7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127, 7'd127
  };
  assign mag = TBL[idx];
endmodule

// File: rtl/wave_gen.sv
// wave_gen: 2-stage waveform sample generator (clk, async rst_n; rd_addr in -> rd_data out; cfg_valid/cfg_wave/cfg_amp in, cfg_ready/cfg_applied out, config switches only at rd_addr=0)
module wave_gen
  import wave_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  input  logic       cfg_valid,
  input  logic [1:0] cfg_wave,
  input  logic [7:0] cfg_amp,
  output logic       cfg_ready,
  output logic       cfg_applied
);
  logic pend;
  wave_t pend_wave, act_wave, eff_wave;
  logic [7:0] pend_amp, act_amp, eff_amp;
  logic [5:0] lut_idx;
  logic [6:0] mag;
  logic [7:0] raw, s1_raw, s1_gain;
  logic signed [8:0] diff;
  logic signed [17:0] prod;
  assign lut_idx = rd_addr[6] ? ~rd_addr[5:0] : rd_addr[5:0];
  sine_quarter_lut u_lut (.idx(lut_idx), .mag(mag));
  assign cfg_ready = ~pend;
  assign cfg_applied = pend && rd_addr == 8'd0;
  assign eff_wave = cfg_applied ? pend_wave : act_wave;
  assign eff_amp = cfg_applied ? pend_amp : act_amp;
  assign raw = eff_wave == WAVE_SINE ? (rd_addr[7] ? 8'd127 - {1'b0, mag} : MIDSCALE + {1'b0, mag})
             : eff_wave == WAVE_SQUARE ? {8{~rd_addr[7]}}
             : eff_wave == WAVE_TRI ? {8{rd_addr[7]}} ^ {rd_addr[6:0], 1'b0}
             : rd_addr;
  assign diff = $signed({1'b0, s1_raw}) - 9'sd128;
  assign prod = diff * $signed({1'b0, s1_gain});
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend <= 1'b0;
      pend_wave <= WAVE_SINE;
      pend_amp <= AMP_UNITY;
      act_wave <= WAVE_SINE;
      act_amp <= AMP_UNITY;
      s1_raw <= MIDSCALE;
      s1_gain <= AMP_UNITY;
      rd_data <= MIDSCALE;
    end else begin
      if (cfg_valid && cfg_ready) begin
        pend <= 1'b1;
        pend_wave <= wave_t'(cfg_wave);
        pend_amp <= clamp_gain(cfg_amp);
      end else if (cfg_applied) pend <= 1'b0;
      if (cfg_applied) begin
        act_wave <= pend_wave;
        act_amp <= pend_amp;
      end
      s1_raw <= raw;
      s1_gain <= eff_amp;
      rd_data <= 8'(prod >>> 7) + MIDSCALE;
    end
endmodule

// File: tb/tb_wave_gen.sv
// tb_wave_gen: scoreboard bench for wave_gen with directed addresses and hand-computed samples
module tb_wave_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] rd_addr = 8'd0;
  logic [7:0] rd_data;
  logic cfg_valid = 1'b0;
  logic [1:0] cfg_wave = 2'd0;
  logic [7:0] cfg_amp = 8'd0;
  logic cfg_ready, cfg_applied;
  typedef struct {int due; logic [7:0] exp; string nm;} exp_t;
  exp_t sb[$];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  wave_gen dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .cfg_valid(cfg_valid), .cfg_wave(cfg_wave), .cfg_amp(cfg_amp),
    .cfg_ready(cfg_ready), .cfg_applied(cfg_applied)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic step(input logic [7:0] a, input string nm, input int exp);
    @(negedge clk);
    cfg_valid = 1'b0;
    rd_addr = a;
    if (exp >= 0) sb.push_back('{cyc + 2, 8'(exp), nm});
    #1;
  endtask
  task automatic offer(input logic [1:0] w, input logic [7:0] amp);
    cfg_valid = 1'b1;
    cfg_wave = w;
    cfg_amp = amp;
  endtask
  initial begin : mon
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk(e.nm, rd_data, e.exp);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin : stim
    logic bad;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_data", rd_data, 8'd128);
    chk("rst_ready", cfg_ready, 1'b1);
    chk("rst_applied", cfg_applied, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(8'd0, "def_a0", 129);
    step(8'd64, "def_a64", 255);
    step(8'd128, "def_a128", 126);
    step(8'd192, "def_a192", 0);
    step(8'd32, "def_a32", 219);
    step(8'd96, "def_a96", 217);
    step(8'd160, "def_a160", 36);
    step(8'd10, "sine_a10", 160);
    chk("align_ready_before", cfg_ready, 1'b1);
    offer(2'd3, 8'd128);
    step(8'd11, "sine_a11", 163);
    chk("align_ready_pending", cfg_ready, 1'b0);
    step(8'd200, "sine_a200", 2);
    chk("align_no_early_apply", cfg_applied, 1'b0);
    step(8'd0, "saw_a0", 0);
    chk("align_applied", cfg_applied, 1'b1);
    chk("align_ready_in_apply", cfg_ready, 1'b0);
    step(8'd200, "saw_a200", 200);
    chk("align_applied_once", cfg_applied, 1'b0);
    chk("align_ready_back", cfg_ready, 1'b1);
    step(8'd37, "saw_a37", 37);
    step(8'd5, "saw_a5", 5);
    offer(2'd1, 8'd64);
    step(8'd0, "sq64_a0", 191);
    chk("sq64_applied", cfg_applied, 1'b1);
    step(8'd128, "sq64_a128", 64);
    step(8'd127, "sq64_a127", 191);
    step(8'd255, "sq64_a255", 64);
    step(8'd3, "sq64_a3", 191);
    offer(2'd1, 8'd0);
    step(8'd0, "amp0_a0", 128);
    step(8'd200, "amp0_a200", 128);
    step(8'd127, "amp0_a127", 128);
    step(8'd7, "amp0_a7", 128);
    offer(2'd1, 8'd200);
    step(8'd0, "amp200_a0", 255);
    step(8'd129, "amp200_a129", 0);
    step(8'd64, "amp200_a64", 255);
    step(8'd1, "amp200_a1", 255);
    offer(2'd2, 8'd128);
    step(8'd0, "tri_a0", 0);
    step(8'd64, "tri_a64", 128);
    step(8'd127, "tri_a127", 254);
    step(8'd128, "tri_a128", 255);
    step(8'd192, "tri_a192", 127);
    step(8'd255, "tri_a255", 1);
    step(8'd20, "tri_a20", 40);
    offer(2'd0, 8'd128);
    step(8'd21, "tri_a21", 42);
    chk("hs_ready_pending", cfg_ready, 1'b0);
    offer(2'd1, 8'd64);
    step(8'd22, "tri_a22", 44);
    offer(2'd1, 8'd64);
    step(8'd0, "hs_sine_a0", 129);
    chk("hs_applied", cfg_applied, 1'b1);
    chk("hs_ready_in_apply", cfg_ready, 1'b0);
    offer(2'd1, 8'd64);
    step(8'd64, "hs_sine_a64", 255);
    chk("hs_ready_back", cfg_ready, 1'b1);
    offer(2'd1, 8'd64);
    step(8'd128, "hs_sine_a128", 126);
    chk("hs_second_accepted", cfg_ready, 1'b0);
    step(8'd0, "hs_sq64_a0", 191);
    chk("hs_second_applied", cfg_applied, 1'b1);
    step(8'd9, "sq64_a9", 191);
    step(8'd0, "bnd_a0", 191);
    chk("bnd_no_apply_at_accept", cfg_applied, 1'b0);
    offer(2'd3, 8'd128);
    bad = 1'b0;
    for (int a = 1; a < 256; a++) begin
      step(8'(a), "bnd_a100", a == 100 ? 191 : -1);
      bad = bad | cfg_applied | cfg_ready;
    end
    chk("bnd_quiet_until_wrap", bad, 1'b0);
    step(8'd0, "bnd_saw_a0", 0);
    chk("bnd_applied_at_wrap", cfg_applied, 1'b1);
    step(8'd77, "bnd_saw_a77", 77);
    step(8'd50, "pre_rst_a50", -1);
    offer(2'd1, 8'd128);
    step(8'd51, "pre_rst_a51", -1);
    chk("rst_pending", cfg_ready, 1'b0);
    #2;
    sb.delete();
    rst_n = 1'b0;
    #1;
    chk("midrst_rd_data", rd_data, 8'd128);
    chk("midrst_ready", cfg_ready, 1'b1);
    chk("midrst_applied", cfg_applied, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(8'd0, "post_rst_a0", 129);
    chk("post_rst_no_apply", cfg_applied, 1'b0);
    step(8'd64, "post_rst_a64", 255);
    step(8'd0, "post_rst_a0b", 129);
    chk("post_rst_no_apply_b", cfg_applied, 1'b0);
    step(8'd128, "post_rst_a128", 126);
    repeat (4) @(negedge clk);
    chk("sb_drain", 8'(sb.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
